// File: rtl/linebuffer_3x3_ctrl_pkg.sv
// linebuffer_3x3_ctrl_pkg: shared FSM encoding, size codes and counter width
package linebuffer_3x3_ctrl_pkg;
  localparam int CNT_W = 8;
  localparam logic [2:0] SEL_8   = 3'd0;
  localparam logic [2:0] SEL_14  = 3'd1;
  localparam logic [2:0] SEL_28  = 3'd2;
  localparam logic [2:0] SEL_56  = 3'd3;
  localparam logic [2:0] SEL_112 = 3'd4;
  localparam logic [2:0] SEL_224 = 3'd5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/linebuffer_3x3_ctrl_size_decode.sv
// lb_size_decode: maps a size code to the feature-map side length
// ports: sel (size code in), len (side length out, 0 for illegal codes)
module lb_size_decode
  import linebuffer_3x3_ctrl_pkg::*;
#(
  parameter int LEN1 = 8,
  parameter int LEN2 = 14,
  parameter int LEN3 = 28,
  parameter int LEN4 = 56,
  parameter int LEN5 = 112,
  parameter int LEN6 = 224
) (
  input  logic [2:0]       sel,
  output logic [CNT_W-1:0] len
);
  always_comb begin
    len = sel == SEL_8   ? CNT_W'(LEN1) :
          sel == SEL_14  ? CNT_W'(LEN2) :
          sel == SEL_28  ? CNT_W'(LEN3) :
          sel == SEL_56  ? CNT_W'(LEN4) :
          sel == SEL_112 ? CNT_W'(LEN5) :
          sel == SEL_224 ? CNT_W'(LEN6) : '0;
  end
endmodule

// File: rtl/linebuffer_3x3_ctrl.sv
// linebuffer_3x3_ctrl: raster counters and 3x3 window control for an 8-lane line buffer
// ports: clk/rst_n; start+cfg_sel launch a layer; in_valid/in_ready/pix_en pixel handshake;
// out_ready downstream backpressure; sel size code to the buffers; win_valid/win_row/win_col
// window strobe and position; busy/done layer status; cfg_err illegal-code pulse
module linebuffer_3x3_ctrl
  import linebuffer_3x3_ctrl_pkg::*;
#(
  parameter int LEN1 = 8,
  parameter int LEN2 = 14,
  parameter int LEN3 = 28,
  parameter int LEN4 = 56,
  parameter int LEN5 = 112,
  parameter int LEN6 = 224
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cfg_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [2:0]       sel,
  output logic             pix_en,
  output logic             win_valid,
  output logic [CNT_W-1:0] win_row,
  output logic [CNT_W-1:0] win_col,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  state_t state, state_n;
  logic [CNT_W-1:0] len, row, col;
  logic start_ok, last_col, last_pix, win_hit;

  lb_size_decode #(
    .LEN1(LEN1), .LEN2(LEN2), .LEN3(LEN3), .LEN4(LEN4), .LEN5(LEN5), .LEN6(LEN6)
  ) u_dec (
    .sel(sel),
    .len(len)
  );

  assign in_ready = (state == RUN) & out_ready;
  assign pix_en   = in_valid & in_ready;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign start_ok = (state == IDLE) & start & (cfg_sel <= SEL_224);
  assign last_col = col == len - CNT_W'(1);
  assign last_pix = last_col & (row == len - CNT_W'(1));
  // a window is complete once two full rows and two columns of context exist
  assign win_hit  = pix_en & (row >= CNT_W'(2)) & (col >= CNT_W'(2));

  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start_ok ? RUN : IDLE) :
              state == RUN  ? (pix_en && last_pix ? DONE : RUN) : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      row       <= '0;
      col       <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= (state == IDLE) & start & (cfg_sel > SEL_224);
      win_valid <= win_hit;
      if (start_ok) begin
        sel <= cfg_sel;
        row <= '0;
        col <= '0;
      end else if (pix_en) begin
        col <= last_col ? '0 : col + CNT_W'(1);
        row <= last_col ? row + CNT_W'(1) : row;
      end
      if (win_hit) begin
        win_row <= row - CNT_W'(2);
        win_col <= col - CNT_W'(2);
      end
    end
  end
endmodule

// File: tb/tb_linebuffer_3x3_ctrl.sv
// tb_linebuffer_3x3_ctrl: self-checking bench with a raster-index reference model
module tb_linebuffer_3x3_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] cfg_sel = 3'd0;
  logic in_ready, pix_en, win_valid, busy, done, cfg_err;
  logic [2:0] sel;
  logic [7:0] win_row, win_col;

  always #5 clk = ~clk;

  linebuffer_3x3_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_sel(cfg_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_ready(out_ready), .sel(sel), .pix_en(pix_en),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col), .busy(busy),
    .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    logic [2:0] cfg;
    logic       err;
    logic       bsy;
    logic [2:0] sel;
  } vec_t;

  int n_chk = 0, n_fail = 0;
  int lens[6] = '{8, 14, 28, 56, 112, 224};
  int m_phase = 0, m_L = 8, m_k = 0, m_sel = 0, e_wr = 0, e_wc = 0;
  logic e_wv = 1'b0, e_err = 1'b0;
  int cnt_acc, cnt_win, first_win_at, done_at, last_wr, last_wc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven at the negedge; compare, then advance the model.
  task automatic tick();
    logic [31:0] act, exp;
    logic acc;
    int r, c;
    #1;
    acc = (m_phase == 1) && out_ready && in_valid;
    exp = {7'b0, (m_phase == 1) && out_ready, acc, e_wv, m_phase == 2, m_phase != 0, e_err,
           3'(m_sel), e_wv ? 8'(e_wr) : 8'd0, e_wv ? 8'(e_wc) : 8'd0};
    act = {7'b0, in_ready, pix_en, win_valid, done, busy, cfg_err, sel,
           e_wv ? win_row : 8'd0, e_wv ? win_col : 8'd0};
    check("cycle", act, exp);
    if (win_valid) begin
      cnt_win++;
      if (first_win_at < 0) first_win_at = cnt_acc;
      last_wr = win_row;
      last_wc = win_col;
    end
    if (done) done_at = cnt_acc;
    if (pix_en) cnt_acc++;
    e_err = (m_phase == 0) && start && (cfg_sel > 3'd5);
    e_wv = 1'b0;
    if (acc) begin
      r = m_k / m_L;
      c = m_k % m_L;
      e_wv = (r >= 2) && (c >= 2);
      if (e_wv) begin
        e_wr = r - 2;
        e_wc = c - 2;
      end
      m_k++;
    end
    if (m_phase == 0 && start && cfg_sel <= 3'd5) begin
      m_phase = 1;
      m_sel = int'(cfg_sel);
      m_L = lens[cfg_sel];
      m_k = 0;
    end else if (m_phase == 2) m_phase = 0;
    else if (acc && m_k == m_L * m_L) m_phase = 2;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outs", {in_ready, pix_en, win_valid, done, busy, cfg_err, sel, win_row, win_col}, 0);
    m_phase = 0; m_sel = 0; m_k = 0; e_wv = 1'b0; e_err = 1'b0; e_wr = 0; e_wc = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: full rate, 1: out_ready toggling, 2: random stalls; inj: accept count at
  // which an extra start(cfg 3) is pushed; stop_at: abandon after that many accepts
  task automatic run_layer(input int code, input int mode, input int inj, input int stop_at);
    int budget;
    logic fin;
    cnt_acc = 0; cnt_win = 0; first_win_at = -1; done_at = -1; last_wr = -1; last_wc = -1;
    budget = 8 * lens[code] * lens[code] + 50;
    fin = 1'b0;
    start = 1'b1; cfg_sel = 3'(code); in_valid = 1'b0; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int n = 0; n < budget; n++) begin
      if (m_phase == 0 || (stop_at >= 0 && cnt_acc >= stop_at)) begin
        fin = 1'b1;
        break;
      end
      in_valid  = mode == 2 ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? n[0] : ($urandom_range(0, 3) != 0);
      start     = inj >= 0 && cnt_acc == inj;
      cfg_sel   = start ? 3'd3 : 3'(code);
      tick();
    end
    if (!fin) begin
      n_chk++;
      n_fail++;
      $display("FAIL layer_timeout: sel %0d got %0d accepts within %0d cycles", code, cnt_acc, budget);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{3'd7, 1'b1, 1'b0, 3'd0};
    vecs[1] = '{3'd1, 1'b0, 1'b1, 3'd1};
    vecs[2] = '{3'd6, 1'b1, 1'b0, 3'd1};
    vecs[3] = '{3'd0, 1'b0, 1'b1, 3'd0};
    vecs[4] = '{3'd7, 1'b1, 1'b0, 3'd0};
    vecs[5] = '{3'd2, 1'b0, 1'b1, 3'd2};
    vecs[6] = '{3'd6, 1'b1, 1'b0, 3'd2};
    cnt_acc = 0; cnt_win = 0; first_win_at = -1; done_at = -1; last_wr = -1; last_wc = -1;
    @(negedge clk);
    do_reset();
    tick();

    foreach (vecs[i]) begin
      start = 1'b1; cfg_sel = vecs[i].cfg; in_valid = 1'b0; out_ready = 1'b0;
      tick();
      start = 1'b0;
      check("tbl_cfg_err", cfg_err, vecs[i].err);
      check("tbl_busy", busy, vecs[i].bsy);
      check("tbl_sel", sel, vecs[i].sel);
      for (int n = 0; n < 1000 && m_phase != 0; n++) begin
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
      end
      in_valid = 1'b0;
      tick();
      check("tbl_idle_busy", busy, 0);
      check("tbl_err_cleared", cfg_err, 0);
    end

    run_layer(0, 0, -1, -1);
    check("l8_accepts", cnt_acc, 64);
    check("l8_windows", cnt_win, 36);
    check("l8_first_win_after", first_win_at, 19);
    check("l8_done_after", done_at, 64);

    run_layer(1, 1, -1, -1);
    check("l14_toggle_accepts", cnt_acc, 196);
    check("l14_toggle_windows", cnt_win, 144);
    check("l14_last_win", {8'(last_wr), 8'(last_wc)}, {8'd11, 8'd11});

    run_layer(0, 0, 10, -1);
    check("ignored_start_sel", sel, 0);
    check("ignored_start_done_after", done_at, 64);
    check("ignored_start_windows", cnt_win, 36);

    run_layer(2, 0, -1, 100);
    check("midreset_accepts", cnt_acc, 100);
    in_valid = 1'b1; out_ready = 1'b1;
    do_reset();
    done_at = -1;
    for (int n = 0; n < 5; n++) tick();
    check("midreset_no_done", done_at, -1);
    in_valid = 1'b0;
    run_layer(2, 2, -1, -1);
    check("fresh_l28_accepts", cnt_acc, 784);
    check("fresh_l28_windows", cnt_win, 676);

    run_layer(3, 0, -1, -1);
    check("b2b_first_windows", cnt_win, 2916);
    run_layer(3, 0, -1, -1);
    check("b2b_second_accepts", cnt_acc, 3136);
    check("b2b_second_windows", cnt_win, 2916);
    check("b2b_second_done_after", done_at, 3136);

    run_layer(4, 2, -1, -1);
    check("rand_l112_accepts", cnt_acc, 12544);
    check("rand_l112_windows", cnt_win, 12100);

    run_layer(1, 2, 7, -1);
    check("rand_l14_windows", cnt_win, 144);
    check("rand_l14_sel", sel, 1);

    run_layer(5, 2, -1, 677);
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) tick();
    check("l224_sel", sel, 5);
    check("l224_windows", cnt_win, 225);
    check("l224_last_win", {8'(last_wr), 8'(last_wc)}, {8'd1, 8'd2});
    do_reset();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
